bp_skid_pipe: RTL and testbench

Ready/valid pipeline whose stages register both directions of the handshake: data and valid forward, ready backward. It complements `bp_pipe`, which registers only the forward path and leaves ready as a combinational chain. It is used where the ready path, not the data path, limits timing, such as long backpressure routes between accelerator tiles and stream FIFOs. Each stage is a 2-entry skid buffer, so full throughput is kept while every combinational ready_i→ready_o path is removed.

---
 rtl/bp_pkg.sv | 4 +
 rtl/bp_skid_stage.sv | 63 ++++++
 rtl/bp_skid_pipe.sv | 49 ++++
 tb/tb_bp_skid_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the skid-buffered ready/valid pipeline
package bp_pkg;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_e;
endpackage

// File: rtl/bp_skid_stage.sv
// bp_skid_stage: one 2-entry skid buffer registering data, valid and ready
// Ports: clk_i, rst_ni (sync, active-low); upstream data_i/valid_i/ready_o;
// downstream data_o/valid_o/ready_i. All outputs decode stage registers only.
module bp_skid_stage
    import bp_pkg::*;
#(
    parameter int DATAW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DATAW-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [DATAW-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);
    skid_state_e      state, state_nx;
    logic [DATAW-1:0] m, m_nx, s, s_nx;
    logic             xfer_in, xfer_out;

    assign valid_o  = state != SKID_EMPTY;
    assign ready_o  = state != SKID_FULL;
    assign data_o   = m;
    assign xfer_in  = valid_i && ready_o;
    assign xfer_out = valid_o && ready_i;

    always_comb begin
        state_nx = state;
        m_nx     = m;
        s_nx     = s;
        case (state)
            SKID_EMPTY: begin
                state_nx = xfer_in ? SKID_BUSY : SKID_EMPTY;
                m_nx     = xfer_in ? data_i : m;
            end
            SKID_BUSY: begin
                state_nx = (xfer_in && !xfer_out) ? SKID_FULL :
                           (!xfer_in && xfer_out) ? SKID_EMPTY : SKID_BUSY;
                m_nx     = (xfer_in && xfer_out) ? data_i : m;
                s_nx     = (xfer_in && !xfer_out) ? data_i : s;
            end
            SKID_FULL: begin
                // ready_o is low here, so only the skid word can move up
                state_nx = xfer_out ? SKID_BUSY : SKID_FULL;
                m_nx     = xfer_out ? s : m;
            end
            default: state_nx = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= SKID_EMPTY;
            m     <= '0;
            s     <= '0;
        end else begin
            state <= state_nx;
            m     <= m_nx;
            s     <= s_nx;
        end
    end
endmodule

// File: rtl/bp_skid_pipe.sv
// bp_skid_pipe: chain of PIPES skid stages cutting both handshake directions
// Ports: clk_i, rst_ni (sync, active-low); upstream data_i/valid_i/ready_o;
// downstream data_o/valid_o/ready_i. PIPES==0 is a combinational pass-through.
module bp_skid_pipe #(
    parameter int DATAW = 8,
    parameter int PIPES = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DATAW-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [DATAW-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);
    if (PIPES == 0) begin : g_pass
        logic unused;
        assign unused  = clk_i ^ rst_ni;
        assign data_o  = data_i;
        assign valid_o = valid_i;
        assign ready_o = ready_i;
    end else begin : g_pipe
        // index k is the link feeding stage k; index PIPES is the pipe output
        logic [DATAW-1:0] data  [PIPES+1];
        logic             valid [PIPES+1];
        logic             ready [PIPES+1];

        assign data[0]      = data_i;
        assign valid[0]     = valid_i;
        assign ready_o      = ready[0];
        assign data_o       = data[PIPES];
        assign valid_o      = valid[PIPES];
        assign ready[PIPES] = ready_i;

        for (genvar i = 0; i < PIPES; i++) begin : g_stage
            bp_skid_stage #(.DATAW(DATAW)) stage (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .data_i  (data[i]),
                .valid_i (valid[i]),
                .ready_o (ready[i]),
                .data_o  (data[i+1]),
                .valid_o (valid[i+1]),
                .ready_i (ready[i+1])
            );
        end
    end
endmodule

// File: tb/tb_bp_skid_pipe.sv
// tb_bp_skid_pipe: directed checks of bp_skid_pipe at PIPES = 0, 1, 2 and 3
module tb_bp_skid_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] p0_din = '0, p1_din = '0, p2_din = '0, p3_din = '0;
    logic       p0_vin = 1'b0, p1_vin = 1'b0, p2_vin = 1'b0, p3_vin = 1'b0;
    logic       p0_rin = 1'b0, p1_rin = 1'b0, p2_rin = 1'b0, p3_rin = 1'b0;
    logic [7:0] p0_dout, p1_dout, p2_dout, p3_dout;
    logic       p0_vout, p1_vout, p2_vout, p3_vout;
    logic       p0_rout, p1_rout, p2_rout, p3_rout;

    int         vectors = 0;
    int         miscompares = 0;
    int         acc, received;
    bit         hs, found, prev_stall;
    logic [7:0] prev_d;
    logic [8:0] exp_d;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    bp_skid_pipe #(.DATAW(8), .PIPES(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(p0_din), .valid_i(p0_vin), .ready_o(p0_rout),
        .data_o(p0_dout), .valid_o(p0_vout), .ready_i(p0_rin));
    bp_skid_pipe #(.DATAW(8), .PIPES(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(p1_din), .valid_i(p1_vin), .ready_o(p1_rout),
        .data_o(p1_dout), .valid_o(p1_vout), .ready_i(p1_rin));
    bp_skid_pipe #(.DATAW(8), .PIPES(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(p2_din), .valid_i(p2_vin), .ready_o(p2_rout),
        .data_o(p2_dout), .valid_o(p2_vout), .ready_i(p2_rin));
    bp_skid_pipe #(.DATAW(8), .PIPES(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(p3_din), .valid_i(p3_vin), .ready_o(p3_rout),
        .data_o(p3_dout), .valid_o(p3_vout), .ready_i(p3_rin));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset, with a word offered that must be dropped
        p2_vin = 1'b1;
        p2_din = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(p2_vout), 32'd0);
        check("rst_data", 32'(p2_dout), 32'd0);
        check("rst_ready", 32'(p2_rout), 32'd1);
        check("rst_ready_p3", 32'(p3_rout), 32'd1);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        p2_vin = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(p2_vout), 32'd0);
        check("post_rst_data", 32'(p2_dout), 32'd0);
        check("post_rst_ready", 32'(p2_rout), 32'd1);

        // back-to-back streaming 0x01..0x10 through PIPES=2
        @(posedge clk); #1;
        p2_vin = 1'b1;
        p2_din = 8'h01;
        p2_rin = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("stream_ready", 32'(p2_rout), 32'd1);
            check("stream_valid", 32'(p2_vout), (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) check("stream_data", 32'(p2_dout), 32'(i - 1));
            @(posedge clk); #1;
            if (i < 15) p2_din = 8'(i + 2);
            else p2_vin = 1'b0;
        end

        // stall: exactly four words fit into two stages
        p2_rin = 1'b0;
        p2_vin = 1'b1;
        p2_din = 8'h01;
        acc    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hs = p2_vin && p2_rout;
            if (hs) acc++;
            @(posedge clk); #1;
            if (hs) p2_din = p2_din + 8'd1;
        end
        check("stall_accepted", 32'(acc), 32'd4);
        check("stall_ready", 32'(p2_rout), 32'd0);
        check("stall_head", 32'(p2_dout), 32'h01);

        // release: drain in order, upstream ready back within two cycles
        p2_vin = 1'b0;
        p2_rin = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("drain_valid", 32'(p2_vout), 32'd1);
            check("drain_data", 32'(p2_dout), 32'(j + 1));
            if (j == 0) check("drain_ready_early", 32'(p2_rout), 32'd0);
            if (j == 2) check("drain_ready_back", 32'(p2_rout), 32'd1);
        end
        @(negedge clk);
        check("drain_empty", 32'(p2_vout), 32'd0);

        // reset while full
        @(posedge clk); #1;
        p2_rin = 1'b0;
        p2_vin = 1'b1;
        p2_din = 8'hA1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hs = p2_vin && p2_rout;
            @(posedge clk); #1;
            if (hs) p2_din = p2_din + 8'd1;
        end
        check("fill_ready", 32'(p2_rout), 32'd0);
        rst_n  = 1'b0;
        p2_din = 8'hEE;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        p2_din = 8'h55;
        p2_rin = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(p2_vout), 32'd0);
        check("midrst_data", 32'(p2_dout), 32'd0);
        check("midrst_ready", 32'(p2_rout), 32'd1);
        @(posedge clk); #1;
        p2_vin = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (p2_vout) found = 1'b1;
        end
        check("midrst_found", 32'(found), 32'd1);
        check("midrst_first", 32'(p2_dout), 32'h55);

        // random traffic through PIPES=3 with scoreboard and stall stability
        @(posedge clk); #1;
        received   = 0;
        prev_stall = 1'b0;
        prev_d     = '0;
        for (int c = 0; c < 60000 && received < 10000; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", 32'(p3_vout), 32'd1);
                check("hold_data", 32'(p3_dout), 32'(prev_d));
            end
            prev_stall = p3_vout && !p3_rin;
            prev_d     = p3_dout;
            hs = p3_vin && p3_rout;
            if (hs) sb.push_back(p3_din);
            if (p3_vout && p3_rin) begin
                exp_d = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
                check("order", 32'(p3_dout), 32'(exp_d));
                received++;
            end
            @(posedge clk); #1;
            if (hs) p3_din = p3_din + 8'd1;
            if (!p3_vin || hs) p3_vin = 1'($urandom_range(0, 1));
            p3_rin = 1'($urandom_range(0, 1));
        end
        check("rand_received", 32'(received), 32'd10000);

        // pass-through at PIPES=0
        for (int i = 0; i < 8; i++) begin
            p0_din = 8'($urandom);
            p0_vin = 1'($urandom_range(0, 1));
            p0_rin = 1'($urandom_range(0, 1));
            #2;
            check("pass_data", 32'(p0_dout), 32'(p0_din));
            check("pass_valid", 32'(p0_vout), 32'(p0_vin));
            check("pass_ready", 32'(p0_rout), 32'(p0_rin));
        end

        // registered ready at PIPES=1
        @(posedge clk); #1;
        p1_vin = 1'b1;
        p1_din = 8'h11;
        p1_rin = 1'b0;
        @(posedge clk); #1;
        p1_din = 8'h22;
        @(posedge clk); #1;
        p1_vin = 1'b0;
        @(negedge clk);
        check("p1_full_ready", 32'(p1_rout), 32'd0);
        check("p1_full_data", 32'(p1_dout), 32'h11);
        #2;
        p1_rin = 1'b1;
        #1;
        check("p1_ready_comb", 32'(p1_rout), 32'd0);
        @(posedge clk); #1;
        check("p1_ready_edge", 32'(p1_rout), 32'd1);
        check("p1_skid_data", 32'(p1_dout), 32'h22);
        p1_rin = 1'b0;
        #1;
        check("p1_ready_hold", 32'(p1_rout), 32'd1);
        check("p1_valid_hold", 32'(p1_vout), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
